// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: sender side of a 4-phase req/ack CDC channel.
// Round-robin arbitration of NUM_REQ local requesters onto one channel.
// The payload is held on data_out for the whole handshake.
// ack_in is synchronized locally, and the FSM only ever looks at the synchronized copy.
module cdc_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  localparam int IDW        = $clog2(NUM_REQ),
  localparam int CW         = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk_s,
  input  logic                      reset_s,
  input  logic [NUM_REQ-1:0]        src_req,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]        src_grant,
  output logic [NUM_REQ-1:0]        src_done,
  output logic                      req_out,
  output logic [DATA_W-1:0]         data_out,
  input  logic                      ack_in,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      err_timeout
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_NACK} state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_ack_sync;
  logic [IDW-1:0]           r_ptr;
  logic [IDW-1:0]           r_grant_id;
  logic [NUM_REQ-1:0]       r_src_grant;
  logic [NUM_REQ-1:0]       r_src_done;
  logic                     r_req_out;
  logic [DATA_W-1:0]        r_data_out;
  logic                     r_busy;
  logic                     r_err;
  logic [CW-1:0]            r_cnt;

  logic                     w_ack_sync;
  logic [IDW-1:0]           w_win;
  logic                     w_found;
  logic [CW-1:0]            w_cnt_inc;

  // Index that is k steps above p, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  assign w_ack_sync  = r_ack_sync[SYNC_STAGES-1];
  assign w_cnt_inc   = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

  assign src_grant   = r_src_grant;
  assign src_done    = r_src_done;
  assign req_out     = r_req_out;
  assign data_out    = r_data_out;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign err_timeout = r_err;

  // ack_in crosses into clk_s through a plain flop chain.
  always_ff @(posedge clk_s or negedge reset_s) begin
    if (!reset_s) r_ack_sync <= '0;
    else          r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
  end

  // The winner is the first requester above the pointer, wrapping around.
  // The loop runs from the far end down, so the nearest match is the last assignment and wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (src_req[rr_idx(r_ptr, k)]) begin
        w_win   = rr_idx(r_ptr, k);
        w_found = 1'b1;
      end
    end
  end

  // Handshake FSM with all outputs registered.
  // The timeout counter restarts on each wait state entry and saturates at TIMEOUT.
  always_ff @(posedge clk_s or negedge reset_s) begin
    if (!reset_s) begin
      r_state     <= IDLE;
      r_ptr       <= IDW'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_src_grant <= '0;
      r_src_done  <= '0;
      r_req_out   <= 1'b0;
      r_data_out  <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_src_grant <= '0;
      r_src_done  <= '0;
      case (r_state)
        IDLE: begin
          // A stale ack from the previous transfer blocks new grants.
          if (w_found && !w_ack_sync) begin
            r_data_out  <= src_data[int'(w_win)*DATA_W +: DATA_W];
            r_grant_id  <= w_win;
            r_src_grant <= NUM_REQ'(1) << w_win;
            r_busy      <= 1'b1;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_req_out <= 1'b1;
          r_cnt     <= '0;
          r_state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (w_ack_sync) begin
            r_req_out <= 1'b0;
            r_cnt     <= '0;
            r_state   <= WAIT_NACK;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CW'(TIMEOUT)) r_err <= 1'b1;
          end
        end
        WAIT_NACK: begin
          if (!w_ack_sync) begin
            r_src_done <= NUM_REQ'(1) << r_grant_id;
            r_ptr      <= r_grant_id;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CW'(TIMEOUT)) r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
